// File: rtl/cbus2axi_axi_eng.sv
// CBUS-to-AXI engine: pops decoded commands and write beats, issues single-ID AXI bursts
// one at a time, and pushes read data. Optional saturating error counter: CBUS2AXI_ERR_CNT_EN.
module cbus2axi_axi_eng #(
   parameter int             IDW       = 4,
   parameter logic [IDW-1:0] AXI_ID    = '0,
   parameter int             MAX_BURST = 16,
   parameter int             CMD_DW    = 46,
   parameter int             DAT_DW    = 37,
   parameter int             RD_DW     = 35
) (
   input  logic              aclk,
   input  logic              areset_n,
   input  logic [CMD_DW-1:0] cwfifo_dataout,
   input  logic              cwfifo_empty,
   output logic              cwfifo_rd_op,
   input  logic [DAT_DW-1:0] dwfifo_dataout,
   input  logic              dwfifo_empty,
   output logic              dwfifo_rd_op,
   output logic [RD_DW-1:0]  rdfifo_datain,
   output logic              rdfifo_wr_op,
   input  logic              rdfifo_full,
   output logic [IDW-1:0]    awid,
   output logic [31:0]       awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic              awvalid,
   input  logic              awready,
   output logic [31:0]       wdata,
   output logic [3:0]        wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [IDW-1:0]    arid,
   output logic [31:0]       araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   output logic              busy,
   output logic              err
`ifdef CBUS2AXI_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_AW, S_W, S_B, S_AR, S_R
   } state_t;

   localparam logic [9:0] MAX_B       = 10'(MAX_BURST);
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   state_t            state_q, state_d;
   logic [CMD_DW-1:0] cmd_q;
   logic [9:0]        rem_q;
   logic [31:0]       addr_q;
   logic [9:0]        beat_q;
   logic              fixed_q;
   logic              run_q;
   logic              err_q;

   logic [1:0]        cmd_amode;
   logic              cmd_rd;
   logic [8:0]        cmd_dwcnt;
   logic [31:0]       cmd_addr;
   logic [9:0]        blen;
   logic [9:0]        blen_m1;
   logic              last_burst;
   logic              beat_last;
   logic              w_hs, b_hs, r_hs, burst_done;
   logic              lastbit_err, err_evt;
   logic              unused_bits;

   assign cmd_amode = cmd_q[45:44];
   assign cmd_rd    = cmd_q[41];
   assign cmd_dwcnt = cmd_q[40:32];
   assign cmd_addr  = cmd_q[31:0];
   // first/last command flags are CBUS-side framing only; the engine never needs them
   assign unused_bits = ^{cmd_q[43:42], blen_m1[9:8]};

   assign blen       = (rem_q > MAX_B) ? MAX_B : rem_q;
   assign blen_m1    = blen - 10'd1;
   assign last_burst = (rem_q <= MAX_B);
   assign beat_last  = (beat_q == blen_m1);

   assign w_hs       = (state_q == S_W) & ~dwfifo_empty & wready;
   assign b_hs       = (state_q == S_B) & bvalid;
   assign r_hs       = (state_q == S_R) & rvalid & ~rdfifo_full;
   assign burst_done = b_hs | (r_hs & rlast);

   // The FIFO last bit must match the final beat of the whole command, not of each burst
   assign lastbit_err = w_hs & (dwfifo_dataout[DAT_DW-1] != (beat_last & last_burst));
   assign err_evt     = lastbit_err | (b_hs & (bresp != 2'b00)) | (r_hs & (rresp != 2'b00));

   assign awid   = AXI_ID;
   assign arid   = AXI_ID;
   assign awsize = 3'b010;
   assign arsize = 3'b010;
   assign err    = err_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      cwfifo_rd_op  = 1'b0;
      dwfifo_rd_op  = 1'b0;
      rdfifo_wr_op  = 1'b0;
      rdfifo_datain = '0;
      awaddr        = '0;
      awlen         = '0;
      awburst       = '0;
      awvalid       = 1'b0;
      araddr        = '0;
      arlen         = '0;
      arburst       = '0;
      arvalid       = 1'b0;
      wdata         = '0;
      wstrb         = '0;
      wlast         = 1'b0;
      wvalid        = 1'b0;
      bready        = 1'b0;
      rready        = 1'b0;
      busy          = (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            // run_q holds off the first pop until the cycle after reset release
            if (run_q && !cwfifo_empty) begin
               cwfifo_rd_op = 1'b1;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: state_d = cmd_rd ? S_AR : S_AW;
         S_AW: begin
            awvalid = 1'b1;
            awaddr  = addr_q;
            awlen   = blen_m1[7:0];
            awburst = fixed_q ? BURST_FIXED : BURST_INCR;
            if (awready) state_d = S_W;
         end
         S_W: begin
            wvalid       = ~dwfifo_empty;
            wdata        = dwfifo_dataout[31:0];
            wstrb        = dwfifo_dataout[35:32];
            wlast        = beat_last;
            dwfifo_rd_op = w_hs;
            if (w_hs && beat_last) state_d = S_B;
         end
         S_B: begin
            bready = 1'b1;
            if (bvalid) state_d = last_burst ? S_IDLE : S_AW;
         end
         S_AR: begin
            arvalid = 1'b1;
            araddr  = addr_q;
            arlen   = blen_m1[7:0];
            arburst = fixed_q ? BURST_FIXED : BURST_INCR;
            if (arready) state_d = S_R;
         end
         S_R: begin
            rready = ~rdfifo_full;
            if (r_hs) begin
               rdfifo_wr_op  = 1'b1;
               rdfifo_datain = RD_DW'({rlast, rresp, rdata});
               // rlast alone ends the burst; its beat position is not checked
               if (rlast) state_d = last_burst ? S_IDLE : S_AR;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         cmd_q   <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         beat_q  <= '0;
         fixed_q <= 1'b0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         run_q <= 1'b1;
         err_q <= err_q | err_evt;
         if (cwfifo_rd_op) cmd_q <= cwfifo_dataout;
         unique case (state_q)
            S_LOAD: begin
               rem_q   <= (cmd_dwcnt == 9'd0) ? 10'd1 : {1'b0, cmd_dwcnt};
               addr_q  <= {cmd_addr[31:2], 2'b00};
               fixed_q <= (cmd_amode == 2'b01);
            end
            S_AW:    if (awready) beat_q <= '0;
            S_W:     if (w_hs)    beat_q <= beat_q + 10'd1;
            default: ;
         endcase
         if (burst_done) begin
            rem_q <= rem_q - blen;
            if (!fixed_q) addr_q <= addr_q + {20'd0, blen, 2'b00};
         end
      end
   end

`ifdef CBUS2AXI_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n)                         err_cnt_q <= '0;
      else if (err_evt && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_cbus2axi_axi_eng.sv
// Directed self-checking bench for cbus2axi_axi_eng: behavioural FIFOs plus a simple AXI slave,
// with every transfer logged and compared against hand-computed values.
`timescale 1ns/1ps
module tb_cbus2axi_axi_eng;

   logic        aclk = 1'b0;
   logic        areset_n;
   logic [45:0] cwfifo_dataout;
   logic        cwfifo_empty;
   logic        cwfifo_rd_op;
   logic [36:0] dwfifo_dataout;
   logic        dwfifo_empty;
   logic        dwfifo_rd_op;
   logic [34:0] rdfifo_datain;
   logic        rdfifo_wr_op;
   logic        rdfifo_full;
   logic [3:0]  awid, arid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, arvalid, arready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic        busy, err;
`ifdef CBUS2AXI_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   cbus2axi_axi_eng dut (
      .aclk(aclk), .areset_n(areset_n),
      .cwfifo_dataout(cwfifo_dataout), .cwfifo_empty(cwfifo_empty), .cwfifo_rd_op(cwfifo_rd_op),
      .dwfifo_dataout(dwfifo_dataout), .dwfifo_empty(dwfifo_empty), .dwfifo_rd_op(dwfifo_rd_op),
      .rdfifo_datain(rdfifo_datain), .rdfifo_wr_op(rdfifo_wr_op), .rdfifo_full(rdfifo_full),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .busy(busy), .err(err)
`ifdef CBUS2AXI_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 aclk = ~aclk;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
   } addr_rec_t;

   logic [45:0] cq[$];
   logic [36:0] dq[$];
   addr_rec_t   aw_q[$];
   addr_rec_t   ar_q[$];
   logic [36:0] w_q[$];
   logic [34:0] rd_q[$];

   int   checks = 0;
   int   errors = 0;
   int   d_pops, b_cnt, viol, full_seen, full_cnt, r_left, r_beat;
   bit   b_pend, full_arm;
   logic [1:0] bresp_cfg;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [45:0] mk_cmd(input logic [1:0] amode, input logic rd,
                                          input logic [8:0] dwcnt, input logic [31:0] addr);
      return {amode, 1'b1, 1'b1, rd, dwcnt, addr};
   endfunction

   function automatic logic [36:0] mk_beat(input logic last, input logic [3:0] strb,
                                           input logic [31:0] d);
      return {last, strb, d};
   endfunction

   task automatic clear_logs();
      aw_q.delete(); ar_q.delete(); w_q.delete(); rd_q.delete();
      d_pops = 0; b_cnt = 0; viol = 0; full_seen = 0;
   endtask

   // One clock: drive slave/FIFO inputs at the falling edge, then log the handshakes
   // that the next rising edge will complete.
   task automatic cycle();
      @(negedge aclk);
      cwfifo_empty   = (cq.size() == 0);
      cwfifo_dataout = cwfifo_empty ? '0 : cq[0];
      dwfifo_empty   = (dq.size() == 0);
      dwfifo_dataout = dwfifo_empty ? '0 : dq[0];
      awready        = ~awready;
      arready        = 1'b1;
      wready         = 1'b1;
      bvalid         = b_pend;
      bresp          = b_pend ? bresp_cfg : 2'b00;
      rvalid         = (r_left > 0);
      rdata          = 32'hD000_0000 | 32'(r_beat);
      rlast          = (r_left == 1);
      rresp          = 2'b00;
      rdfifo_full    = (full_cnt > 0);
      if (full_cnt > 0) full_cnt--;
      #1;
      if (rdfifo_full) full_seen++;
      if (rdfifo_full && rready) viol++;
      if (awvalid && wvalid) viol++;
      if (cwfifo_rd_op && cq.size() > 0) void'(cq.pop_front());
      if (dwfifo_rd_op) begin
         if (!(wvalid && wready)) viol++;
         if (dq.size() > 0) void'(dq.pop_front());
         d_pops++;
      end
      if (awvalid && awready) aw_q.push_back('{addr: awaddr, len: awlen, burst: awburst});
      if (wvalid && wready) begin
         w_q.push_back({wlast, wstrb, wdata});
         if (wlast) b_pend = 1'b1;
      end
      if (bvalid && bready) begin
         b_pend = 1'b0;
         b_cnt++;
      end
      if (arvalid && arready) begin
         ar_q.push_back('{addr: araddr, len: arlen, burst: arburst});
         r_left = int'(arlen) + 1;
         r_beat = 0;
      end
      if (rvalid && rready) begin
         if (!rdfifo_wr_op) viol++;
         r_left--;
         r_beat++;
      end
      if (rdfifo_wr_op) begin
         rd_q.push_back(rdfifo_datain);
         if (full_arm) begin
            full_cnt = 3;
            full_arm = 1'b0;
         end
      end
   endtask

   task automatic run_cmd(input string tag, input int budget);
      bit seen = 1'b0;
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         cycle();
         if (busy)      seen = 1'b1;
         else if (seen) done = 1'b1;
      end
      check({tag, "_done"}, 64'(done), 64'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [36:0] beats[$];
      int          wl_cnt;

      areset_n = 1'b0;
      cwfifo_dataout = '0; cwfifo_empty = 1'b1; dwfifo_dataout = '0; dwfifo_empty = 1'b1;
      rdfifo_full = 1'b0; awready = 1'b0; arready = 1'b0; wready = 1'b0;
      bresp = '0; bvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      b_pend = 1'b0; full_arm = 1'b0; full_cnt = 0; r_left = 0; r_beat = 0; bresp_cfg = 2'b00;
      clear_logs();

      // Reset state
      repeat (3) @(negedge aclk);
      #1;
      check("rst_ctrl", {busy, awvalid, wvalid, bready, arvalid, rready,
                         cwfifo_rd_op, dwfifo_rd_op, rdfifo_wr_op, err}, '0);
      check("rst_awid", awid, 4'h0);
      areset_n = 1'b1;
      cycle();

      // Write, 4 beats, unaligned address
      clear_logs();
      beats.delete();
      for (int i = 0; i < 4; i++) beats.push_back(mk_beat(i == 3, 4'hF - 4'(i), 32'hC0DE_0000 + 32'(i)));
      foreach (beats[i]) dq.push_back(beats[i]);
      cq.push_back(mk_cmd(2'b00, 1'b0, 9'd4, 32'h1000_0002));
      run_cmd("t1", 100);
      check("t1_aw_n", aw_q.size(), 1);
      check("t1_aw", aw_q[0], {32'h1000_0000, 8'd3, 2'b01});
      check("t1_w_n", w_q.size(), 4);
      for (int i = 0; i < 4; i++) check($sformatf("t1_w%0d", i), w_q[i], beats[i]);
      check("t1_pops", d_pops, 4);
      check("t1_b", b_cnt, 1);
      check("t1_err", err, 0);
      check("t1_viol", viol, 0);

      // Write, 20 beats split 16 + 4
      clear_logs();
      for (int i = 0; i < 20; i++) dq.push_back(mk_beat(i == 19, 4'hF, 32'h0000_0100 + 32'(i)));
      cq.push_back(mk_cmd(2'b00, 1'b0, 9'd20, 32'h0000_0000));
      run_cmd("t2", 300);
      check("t2_aw_n", aw_q.size(), 2);
      check("t2_aw0", aw_q[0], {32'h0000_0000, 8'd15, 2'b01});
      check("t2_aw1", aw_q[1], {32'h0000_0040, 8'd3, 2'b01});
      check("t2_pops", d_pops, 20);
      check("t2_b", b_cnt, 2);
      wl_cnt = 0;
      foreach (w_q[i]) if (w_q[i][36]) wl_cnt++;
      check("t2_wlast_n", wl_cnt, 2);
      check("t2_wlast16", w_q[15][36], 1);
      check("t2_wlast20", w_q[19][36], 1);
      check("t2_w17data", w_q[16][31:0], 32'h0000_0110);
      check("t2_err", err, 0);

      // Read, 2 beats FIXED, read FIFO full for 3 cycles after the first push
      clear_logs();
      full_arm = 1'b1;
      cq.push_back(mk_cmd(2'b01, 1'b1, 9'd2, 32'h2000_0008));
      run_cmd("t3", 100);
      check("t3_ar_n", ar_q.size(), 1);
      check("t3_ar", ar_q[0], {32'h2000_0008, 8'd1, 2'b00});
      check("t3_rd_n", rd_q.size(), 2);
      check("t3_rd0", rd_q[0], {1'b0, 2'b00, 32'hD000_0000});
      check("t3_rd1", rd_q[1], {1'b1, 2'b00, 32'hD000_0001});
      check("t3_full", full_seen, 3);
      check("t3_viol", viol, 0);

      // Read, dwcnt=0 means one beat
      clear_logs();
      cq.push_back(mk_cmd(2'b00, 1'b1, 9'd0, 32'h4000_0006));
      run_cmd("t5", 100);
      check("t5_ar", ar_q[0], {32'h4000_0004, 8'd0, 2'b01});
      check("t5_rd_n", rd_q.size(), 1);
      check("t5_rd0", rd_q[0], {1'b1, 2'b00, 32'hD000_0000});
      check("t5_err", err, 0);

      // Write with SLVERR response, then a clean write
      clear_logs();
      bresp_cfg = 2'b10;
      dq.push_back(mk_beat(1'b1, 4'hF, 32'hBAD0_0001));
      cq.push_back(mk_cmd(2'b00, 1'b0, 9'd1, 32'h3000_0000));
      run_cmd("t4a", 100);
      check("t4_err", err, 1);
      clear_logs();
      bresp_cfg = 2'b00;
      dq.push_back(mk_beat(1'b0, 4'h3, 32'h1111_0000));
      dq.push_back(mk_beat(1'b1, 4'hC, 32'h1111_0001));
      cq.push_back(mk_cmd(2'b00, 1'b0, 9'd2, 32'h3000_0010));
      run_cmd("t4b", 100);
      check("t4_aw", aw_q[0], {32'h3000_0010, 8'd1, 2'b01});
      check("t4_pops", d_pops, 2);
      check("t4_err_sticky", err, 1);
`ifdef CBUS2AXI_ERR_CNT_EN
      check("t4_errcnt", err_cnt, 1);
`endif

      // Reset while stalled in W
      clear_logs();
      dq.push_back(mk_beat(1'b0, 4'hF, 32'h5555_0000));
      cq.push_back(mk_cmd(2'b00, 1'b0, 9'd4, 32'h5000_0000));
      for (int i = 0; i < 50 && w_q.size() < 1; i++) cycle();
      cycle();
      cycle();
      check("t6_pre_busy", busy, 1);
      check("t6_pre_wvalid", wvalid, 0);
      @(negedge aclk);
      areset_n = 1'b0;
      #1;
      check("t6_rst_ctrl", {busy, awvalid, wvalid, bready, arvalid, rready,
                            cwfifo_rd_op, dwfifo_rd_op, rdfifo_wr_op, err}, '0);
      check("t6_rst_wdata", wdata, 32'h0);
      @(negedge aclk);
      #1;
      check("t6_idle", busy, 0);
      cq.delete(); dq.delete();
      b_pend = 1'b0; r_left = 0; full_cnt = 0;
      areset_n = 1'b1;
      cycle();
      check("t6_err_clr", err, 0);
`ifdef CBUS2AXI_ERR_CNT_EN
      check("t6_errcnt_clr", err_cnt, 0);
`endif

      // Write with FIFO last bit on beat 2 of 3
      clear_logs();
      dq.push_back(mk_beat(1'b0, 4'hF, 32'h7000_0000));
      dq.push_back(mk_beat(1'b1, 4'hF, 32'h7000_0001));
      dq.push_back(mk_beat(1'b0, 4'hF, 32'h7000_0002));
      cq.push_back(mk_cmd(2'b00, 1'b0, 9'd3, 32'h6000_0000));
      run_cmd("t7", 100);
      check("t7_aw", aw_q[0], {32'h6000_0000, 8'd2, 2'b01});
      check("t7_w_n", w_q.size(), 3);
      check("t7_w2", w_q[2], mk_beat(1'b1, 4'hF, 32'h7000_0002));
      check("t7_pops", d_pops, 3);
      check("t7_err", err, 1);
`ifdef CBUS2AXI_ERR_CNT_EN
      check("t7_errcnt", err_cnt, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cbus2axi_axi_eng.md
Name: cbus2axi_axi_eng

Overview:
Downstream stage of the CBUS master interface. It pops decoded commands from the command FIFO and write beats from the write-data FIFO. It drives single-ID AXI read and write bursts, split at MAX_BURST beats, and pushes AXI read data into the read-data FIFO. Exactly one AXI transaction is outstanding at a time.

Parameters:
AXI_ID, 4'h0, constant awid/arid value
IDW, 4, AXI ID width
MAX_BURST, 16, maximum beats per AXI burst (power of 2, 1..256)
CMD_DW, 46, command word width: {amode[1:0], first, last, cmd, dwcnt[8:0], addr[31:0]}
DAT_DW, 37, write-data word width: {last, byten[3:0], wdata[31:0]}
RD_DW, 35, read FIFO word width: {rlast, rresp[1:0], rdata[31:0]}

Ports:
aclk  in  1  clock
areset_n  in  1  reset
cwfifo_dataout  in  CMD_DW  command head; FIFOs are show-ahead
cwfifo_empty  in  1  command FIFO empty
cwfifo_rd_op  out  1  command pop
dwfifo_dataout  in  DAT_DW  write-data head
dwfifo_empty  in  1  write-data FIFO empty
dwfifo_rd_op  out  1  write-data pop
rdfifo_datain  out  RD_DW  read data push word
rdfifo_wr_op  out  1  read FIFO push
rdfifo_full  in  1  read FIFO full
awid/arid  out  IDW  = AXI_ID
awaddr/araddr  out  32  burst address
awlen/arlen  out  8  beats-1
awsize/arsize  out  3  constant 3'b010
awburst/arburst  out  2  FIXED if amode==2'b01, else INCR
awvalid/arvalid  out  1  address valid
awready/arready  in  1  address ready
wdata  out  32  write data
wstrb  out  4  byte enables
wlast  out  1  last beat of burst
wvalid  out  1  write valid
wready  in  1  write ready
bresp  in  2  write response
bvalid  in  1  response valid
bready  out  1  response ready
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  last read beat
rvalid  in  1  read valid
rready  out  1  read ready
busy  out  1  FSM not IDLE
err  out  1  sticky error flag

Behaviour:
- Reset: aclk domain, areset_n asynchronous, active-low. All outputs 0; FSM goes to IDLE; internal counters 0.
- Mid-transfer reset: abandons the transaction immediately. No completion is required.
- FSM states: IDLE, LOAD, AW, W, B, AR, R.
- IDLE: if ~cwfifo_empty, pulse cwfifo_rd_op for 1 cycle, latch the head word, go to LOAD.
- LOAD: rem = (dwcnt==0) ? 1 : dwcnt; addr = {addr[31:2], 2'b00}. Go to AW if cmd==0, AR if cmd==1.
- Burst length: blen = min(rem, MAX_BURST); awlen/arlen = blen-1.
- AW/AR: hold valid and stable until ready is sampled high. Then go to W (beat counter = 0) or R.
- W: wvalid = ~dwfifo_empty. Fields are taken from the FIFO head: wdata/wstrb = head. wlast = (beat == blen-1).
  - On wvalid & wready: dwfifo_rd_op=1 in the same cycle (combinational); beat increments.
  - If the FIFO last bit is set on a non-final beat of the command, or clear on the final beat, set err. Data is still sent.
  - After the wlast handshake, go to B.
- B: bready=1. On bvalid, set err if bresp!=0. rem -= blen. If INCR, addr += 4*blen (32-bit wrap). If rem==0 go to IDLE, else go to AW.
- AR/R: rready = ~rdfifo_full. On rvalid & rready: rdfifo_wr_op=1 with {rlast, rresp, rdata} in the same cycle. Set err if rresp!=0.
  - On the rlast beat: rem -= blen and addr advances as in B. If rem==0 go to IDLE, else go to AR.
- rlast arriving early or late is not checked. The burst ends on rlast.
- No simultaneous AW and W. The W phase starts only after the AW handshake.
- The command pop happens only in IDLE, so no back-to-back pop without an intervening LOAD.
- err is sticky and cleared only by reset.

Optional Feature:
CBUS2AXI_ERR_CNT_EN
- Defined: adds output err_cnt[7:0]. It counts every non-OKAY bresp, every non-OKAY rresp beat and every last-bit mismatch. It saturates at 8'hFF and resets to 0.
- Undefined: no err_cnt port; only sticky err exists.

Test Plan:
- Write, dwcnt=4, addr 0x1000_0002, amode 0, 4 data beats queued -> one AW: awaddr 0x1000_0000, awlen 3, INCR; 4 W beats; wlast on beat 4; bresp OKAY; err=0; back to IDLE.
- Write, dwcnt=20, MAX_BURST=16 -> AW(0x0, len 15) then B, then AW(0x40, len 3) then B; 20 dwfifo pops total.
- Read, dwcnt=2, amode 01; rdfifo_full held for 3 cycles mid-burst -> arburst FIXED, arlen 1; rready low while full; 2 pushes {rlast, 00, rdata} in order.
- Write with bresp=2'b10 -> err=1 and stays 1. Next command executes normally; err_cnt=1 when CBUS2AXI_ERR_CNT_EN is defined.
- dwcnt=0 read -> arlen 0, single push.
- Reset asserted while in W -> all outputs 0 and IDLE next cycle.
- Write whose FIFO last bit is set on beat 2 of 3 -> err=1; all 3 beats still sent.
